// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional overflow flag: define BCD_OVF_CHK_EN to add the ovf port.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_OVF_CHK_EN
  ,
  output logic                  ovf
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;

`ifdef BCD_OVF_CHK_EN
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;
`endif

  // Add 3 to every digit >= 5 so the following shift carries correctly.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
`ifdef BCD_OVF_CHK_EN
    flag_d    = flag_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
`ifdef BCD_OVF_CHK_EN
          flag_d    = 1'b0;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - CNT_W'(1);
`ifdef BCD_OVF_CHK_EN
        flag_d    = flag_q | adj[BCD_W-1];
`endif
        if (cnt_q == CNT_W'(1))
          state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
`ifdef BCD_OVF_CHK_EN
        ovf_d   = flag_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef BCD_OVF_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: a 3-digit and a 2-digit instance run side by side
// against a decimal-arithmetic reference model.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin_in = 8'd0;
  logic        busy, done, busy2, done2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;
`ifdef BCD_OVF_CHK_EN
  logic        ovf, ovf2;
`endif

  int  total = 0;
  int  bad = 0;
  time t_last_done = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd)
`ifdef BCD_OVF_CHK_EN
    , .ovf(ovf)
`endif
  );

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2)
`ifdef BCD_OVF_CHK_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal digits of v, least significant first, truncated to nd digits.
  function automatic int bcd_ref(input int v, input int nd);
    int r = 0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int nd);
    int p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return p;
  endfunction

  // Caller has already driven start=1 and bin_in=v ahead of the accepting edge.
  task automatic run(input logic [7:0] v, input bit noisy);
    int cyc = 0;
    int bcnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 30) begin
      if (busy) bcnt++;
      if (noisy) begin
        bin_in = 8'($urandom);
        start  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'd9);
    chk("busy_len", 32'(bcnt), 32'd9);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done2_sync", 32'(done2), 32'd1);
    chk("bcd3", 32'(bcd), 32'(bcd_ref(int'(v), 3)));
    chk("bcd2", 32'(bcd2), 32'(bcd_ref(int'(v), 2)));
`ifdef BCD_OVF_CHK_EN
    chk("ovf3", 32'(ovf), 32'(int'(v) >= pow10(3)));
    chk("ovf2", 32'(ovf2), 32'(int'(v) >= pow10(2)));
`endif
    t_last_done = $time;
  endtask

  task automatic idle_after(input logic [7:0] v);
    @(posedge clk); #1;
    chk("done_width", 32'(done), 32'd0);
    chk("no_restart", 32'(busy), 32'd0);
    chk("bcd_hold", 32'(bcd), 32'(bcd_ref(int'(v), 3)));
  endtask

  task automatic convert(input logic [7:0] v, input bit noisy);
    start  = 1'b1;
    bin_in = v;
    run(v, noisy);
    idle_after(v);
  endtask

  initial begin
    logic [7:0] dir [6];
    time t1;
    dir = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd255, 8'd123};

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_bcd2", 32'(bcd2), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dir[i]) convert(dir[i], 1'b0);
    convert(8'd99, 1'b0);

    // start and bin_in toggle while busy: result and single done unaffected
    convert(8'd200, 1'b1);
    convert(8'd173, 1'b1);

    // back-to-back: new start in the done cycle
    start = 1'b1; bin_in = 8'd128;
    run(8'd128, 1'b0);
    t1 = t_last_done;
    start = 1'b1; bin_in = 8'd42;
    run(8'd42, 1'b0);
    chk("b2b_gap", 32'((t_last_done - t1) / 10), 32'd10);
    idle_after(8'd42);

    // reset in the middle of SHIFT
    start = 1'b1; bin_in = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    chk("mid_rst_bcd2", 32'(bcd2), 32'd0);
`ifdef BCD_OVF_CHK_EN
    chk("mid_rst_ovf2", 32'(ovf2), 32'd0);
`endif
    @(posedge clk); #1;
    chk("rst_hold_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    convert(8'd37, 1'b0);

    repeat (40) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      convert(v, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
